// File: rtl/dmem_arbiter_if.sv
// +-----------------------------------------------------------------------------+
// | Interface   : dmem_arbiter_if                                               |
// | Description : Request/ack bundle for one requester of the data-memory       |
// |               arbiter.                                                      |
// |   req    master->slave  request, held until ack                             |
// |   wr     master->slave  1 = write, 0 = read                                 |
// |   addr   master->slave  access address (AW bits)                            |
// |   wdata  master->slave  write data (DW bits)                                |
// |   ack    slave->master  one-cycle completion pulse                          |
// |   rdata  slave->master  read data, valid while ack=1                        |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

interface dmem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          req;
   logic          wr;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          ack;
   logic [DW-1:0] rdata;

   // The requester drives the request fields and receives the completion.
   modport master (
      output req, wr, addr, wdata,
      input  ack, rdata
   );

   // The arbiter samples the request fields and returns the completion.
   modport slave (
      input  req, wr, addr, wdata,
      output ack, rdata
   );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// +-----------------------------------------------------------------------------+
// | Module      : dmem_arbiter                                                  |
// | Description : Shares a single-port data memory between the CPU (port0) and  |
// |               a DMA/UART buffer engine (port1). Each access is a            |
// |               multi-cycle transaction: IDLE grants, BUSY drives the memory  |
// |               strobes for MEM_LAT cycles from latched request fields, DONE  |
// |               pulses the winner's ack with the captured read data.          |
// | Ports       : clk        system clock, rising edge                          |
// |               reset      asynchronous active-high reset                     |
// |               port0      CPU requester (slave side of dmem_arbiter_if)      |
// |               port1      DMA requester (slave side of dmem_arbiter_if)      |
// |               mem_rd     memory read strobe                                 |
// |               mem_wr     memory write strobe                                |
// |               mem_addr   memory address                                     |
// |               mem_wdata  memory write data                                  |
// |               mem_rdata  memory read data                                   |
// |               busy       high while a transaction is in BUSY or DONE        |
// |               owner      requester currently granted (valid when busy=1)    |
// | Options     : define DMEM_ARB_CPU_PRIO_EN for fixed CPU priority on ties;   |
// |               default build arbitrates ties round-robin.                    |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module dmem_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MEM_LAT = 2     // memory cycles per access, 1..15
) (
   input  wire            clk,
   input  wire            reset,
   dmem_arbiter_if.slave  port0,
   dmem_arbiter_if.slave  port1,
   output logic           mem_rd,
   output logic           mem_wr,
   output logic [AW-1:0]  mem_addr,
   output logic [DW-1:0]  mem_wdata,
   input  wire  [DW-1:0]  mem_rdata,
   output logic           busy,
   output logic           owner
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

   state_t        state;
   logic [3:0]    cnt;
   logic          last;
   logic          sel;
   logic          wr_l;
   logic [AW-1:0] addr_l;
   logic [DW-1:0] wdata_l;
   logic [DW-1:0] rdata_l;
   logic          ack0;
   logic          ack1;
   logic [DW-1:0] hold0;     // rdata0 value between completions
   logic [DW-1:0] hold1;     // rdata1 value between completions

   // Arbitration decision, only acted upon in IDLE.
   logic          any_req;
   logic          win;
   logic          win_wr;
   logic [AW-1:0] win_addr;
   logic [DW-1:0] win_wdata;

   always_comb begin
      any_req = port0.req | port1.req;
`ifdef DMEM_ARB_CPU_PRIO_EN
      // CPU wins whenever it is requesting; last is tracked but not consulted.
      win = ~port0.req;
`else
      // On a tie the requester that did not win last time goes next.
      win = (port0.req & port1.req) ? ~last : port1.req;
`endif
      win_wr    = win ? port1.wr    : port0.wr;
      win_addr  = win ? port1.addr  : port0.addr;
      win_wdata = win ? port1.wdata : port0.wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         last    <= 1'b1;      // makes requester 0 the first tie winner
         sel     <= 1'b0;
         wr_l    <= 1'b0;
         addr_l  <= '0;
         wdata_l <= '0;
         rdata_l <= '0;
         ack0    <= 1'b0;
         ack1    <= 1'b0;
         hold0   <= '0;
         hold1   <= '0;
         mem_rd  <= 1'b0;
         mem_wr  <= 1'b0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  sel     <= win;
                  last    <= win;
                  wr_l    <= win_wr;
                  addr_l  <= win_addr;
                  wdata_l <= win_wdata;
                  cnt     <= LAT_M1;
                  mem_rd  <= ~win_wr;
                  mem_wr  <= win_wr;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (cnt == 4'd0) begin
                  // Last memory cycle: capture data (ignored for writes),
                  // drop the strobes and raise the owner's ack.
                  rdata_l <= mem_rdata;
                  mem_rd  <= 1'b0;
                  mem_wr  <= 1'b0;
                  ack0    <= ~sel;
                  ack1    <= sel;
                  state   <= DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE: begin
               // Keep the completed read data visible on the owner's rdata.
               if (sel) begin
                  hold1 <= rdata_l;
               end else begin
                  hold0 <= rdata_l;
               end
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign mem_addr    = addr_l;
   assign mem_wdata   = wdata_l;
   assign busy        = (state != IDLE);
   assign owner       = sel;

   assign port0.ack   = ack0;
   assign port1.ack   = ack1;
   assign port0.rdata = ack0 ? rdata_l : hold0;
   assign port1.rdata = ack1 ? rdata_l : hold1;

endmodule

`default_nettype wire
